// File: rtl/tap_pkg.sv
// Shared widths and types for the tap-term generator that feeds the FFE/DFE adder.
package tap_pkg;

  localparam int SYM_BITS  = 8;
  localparam int WT_BITS   = 8;
  localparam int N_TAPS    = 4;
  localparam int TERM_BITS = 16;

  // Full-precision signed product width before saturation or extension.
  localparam int PROD_BITS = SYM_BITS + WT_BITS;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } tap_state_t;

endpackage

// File: rtl/tap_terms_gen_sat_mul.sv
// Combinational signed multiply, clipped or sign-extended to term_bits.
module sat_mul
  import tap_pkg::*;
#(
  parameter int sym_bits  = SYM_BITS,
  parameter int wt_bits   = WT_BITS,
  parameter int term_bits = TERM_BITS
) (
  input  logic signed [sym_bits-1:0]  a,
  input  logic signed [wt_bits-1:0]   b,
  output logic signed [term_bits-1:0] y
);

  localparam int prod_bits = sym_bits + wt_bits;

  logic signed [prod_bits-1:0] prod;

  assign prod = a * b;

  generate
    if (term_bits < prod_bits) begin : g_sat
      localparam logic signed [prod_bits-1:0] max_v =
        {{(prod_bits-term_bits+1){1'b0}}, {(term_bits-1){1'b1}}};
      localparam logic signed [prod_bits-1:0] min_v =
        {{(prod_bits-term_bits+1){1'b1}}, {(term_bits-1){1'b0}}};

      always_comb begin
        y = prod[term_bits-1:0];
        if (prod > max_v)      y = max_v[term_bits-1:0];
        else if (prod < min_v) y = min_v[term_bits-1:0];
      end
    end else begin : g_ext
      assign y = term_bits'(prod);
    end
  endgenerate

endmodule

// File: rtl/tap_terms_gen.sv
// Symbol history line times writable tap weights, emitting registered saturated products.
module tap_terms_gen
  import tap_pkg::*;
#(
  parameter int sym_bits  = SYM_BITS,
  parameter int wt_bits   = WT_BITS,
  parameter int n_taps    = N_TAPS,
  parameter int term_bits = TERM_BITS,
  parameter int addr_bits = (n_taps > 1) ? $clog2(n_taps) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [sym_bits-1:0]  in_sym,
  input  logic                        clear,
  input  logic                        wt_we,
  input  logic [addr_bits-1:0]        wt_addr,
  input  logic signed [wt_bits-1:0]   wt_data,
  output logic                        out_valid,
  output logic signed [term_bits-1:0] out_terms [n_taps]
);

  localparam int cnt_bits = $clog2(n_taps + 1);
  localparam logic [cnt_bits-1:0]  full_cnt = cnt_bits'(n_taps);
  localparam logic [addr_bits:0]   taps_lim = (addr_bits+1)'(n_taps);

  logic signed [sym_bits-1:0]  hist   [n_taps];
  logic signed [wt_bits-1:0]   wt     [n_taps];
  logic signed [term_bits-1:0] term_c [n_taps];
  logic [cnt_bits-1:0]         fill_cnt;
  tap_state_t                  state;
  logic                        v1;

  for (genvar k = 0; k < n_taps; k++) begin : g_mul
    sat_mul #(
      .sym_bits (sym_bits),
      .wt_bits  (wt_bits),
      .term_bits(term_bits)
    ) u_mul (
      .a(hist[k]),
      .b(wt[k]),
      .y(term_c[k])
    );
  end

  // Stage 1: history shift and fill tracking; clear beats an incoming symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < n_taps; k++) hist[k] <= '0;
      fill_cnt <= '0;
      state    <= FILL;
      v1       <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < n_taps; k++) hist[k] <= '0;
      fill_cnt <= '0;
      state    <= FILL;
      v1       <= 1'b0;
    end else if (in_valid) begin
      hist[0] <= in_sym;
      for (int k = 1; k < n_taps; k++) hist[k] <= hist[k-1];
      if (state == RUN) begin
        v1 <= 1'b1;
      end else if (fill_cnt == full_cnt - 1'b1) begin
        fill_cnt <= full_cnt;
        state    <= RUN;
        v1       <= 1'b1;
      end else begin
        fill_cnt <= fill_cnt + 1'b1;
        v1       <= 1'b0;
      end
    end else begin
      v1 <= 1'b0;
    end
  end

  // Weight bank survives clear; out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < n_taps; k++) wt[k] <= '0;
    end else if (wt_we && ({1'b0, wt_addr} < taps_lim)) begin
      wt[wt_addr] <= wt_data;
    end
  end

  // Stage 2: products always register; out_valid qualifies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int k = 0; k < n_taps; k++) out_terms[k] <= '0;
    end else begin
      out_valid <= v1 & ~clear;
      for (int k = 0; k < n_taps; k++) out_terms[k] <= term_c[k];
    end
  end

endmodule

// File: tb/tb_tap_terms_gen.sv
// Directed plus random checks of tap_terms_gen in a 4-tap/16-bit and a 3-tap/10-bit build.
module tb_tap_terms_gen;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [7:0] in_sym;
  logic              clear;
  logic              wt_we;
  logic [1:0]        wt_addr;
  logic signed [7:0] wt_data;

  logic               out_valid_a;
  logic signed [15:0] terms_a [4];
  logic               out_valid_b;
  logic signed [9:0]  terms_b [3];

  int total = 0;
  int bad   = 0;

  // Reference model: shared history, per-build weights, fill and pending state.
  int m_hist [4];
  int m_wa   [4];
  int m_wb   [3];
  int fill_a, fill_b;
  bit pend_a, pend_b, exp_va, exp_vb;
  logic [63:0] exp_q_a [$];
  logic [29:0] exp_q_b [$];

  tap_terms_gen #(.sym_bits(8), .wt_bits(8), .n_taps(4), .term_bits(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym), .clear(clear),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(out_valid_a), .out_terms(terms_a)
  );

  tap_terms_gen #(.sym_bits(8), .wt_bits(8), .n_taps(3), .term_bits(10)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym), .clear(clear),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(out_valid_b), .out_terms(terms_b)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int p, input int tb);
    int hi, lo;
    hi = (1 << (tb - 1)) - 1;
    lo = -(1 << (tb - 1));
    if (p > hi) return hi;
    if (p < lo) return lo;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] packed_a();
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = terms_a[k];
    return r;
  endfunction

  function automatic logic [63:0] packed_b();
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) r[k*10 +: 10] = terms_b[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin m_hist[k] = 0; m_wa[k] = 0; end
    for (int k = 0; k < 3; k++) m_wb[k] = 0;
    fill_a = 0; fill_b = 0;
    pend_a = 0; pend_b = 0; exp_va = 0; exp_vb = 0;
    exp_q_a.delete();
    exp_q_b.delete();
  endtask

  task automatic check_outputs();
    logic [63:0] e;
    chk("valid_a", {63'd0, out_valid_a}, {63'd0, exp_va});
    chk("valid_b", {63'd0, out_valid_b}, {63'd0, exp_vb});
    if (exp_va && exp_q_a.size() > 0) begin
      e = exp_q_a.pop_front();
      chk("terms_a", packed_a(), e);
    end
    if (exp_vb && exp_q_b.size() > 0) begin
      e = {34'd0, exp_q_b.pop_front()};
      chk("terms_b", packed_b(), e);
    end
  endtask

  // One clock: check what the last edge produced, then drive and model the next edge.
  task automatic step(input logic iv, input logic signed [7:0] sym, input logic clr,
                      input logic we, input logic [1:0] addr, input logic signed [7:0] data);
    logic [63:0] ea;
    logic [29:0] eb;
    @(negedge clk);
    check_outputs();
    exp_va = pend_a && !clr;
    exp_vb = pend_b && !clr;
    if (exp_va) begin
      for (int k = 0; k < 4; k++) ea[k*16 +: 16] = 16'(sat(m_hist[k] * m_wa[k], 16));
      exp_q_a.push_back(ea);
    end
    if (exp_vb) begin
      for (int k = 0; k < 3; k++) eb[k*10 +: 10] = 10'(sat(m_hist[k] * m_wb[k], 10));
      exp_q_b.push_back(eb);
    end
    in_valid = iv; in_sym = sym; clear = clr;
    wt_we = we; wt_addr = addr; wt_data = data;
    if (we) begin
      m_wa[addr] = int'(data);
      if (addr < 3) m_wb[addr] = int'(data);
    end
    pend_a = 0; pend_b = 0;
    if (clr) begin
      for (int k = 0; k < 4; k++) m_hist[k] = 0;
      fill_a = 0; fill_b = 0;
    end else if (iv) begin
      for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = int'(sym);
      fill_a = (fill_a < 4) ? fill_a + 1 : 4;
      fill_b = (fill_b < 3) ? fill_b + 1 : 3;
      pend_a = (fill_a == 4);
      pend_b = (fill_b == 3);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'sd0, 1'b0, 1'b0, 2'd0, 8'sd0);
  endtask

  task automatic feed(input logic signed [7:0] sym);
    step(1'b1, sym, 1'b0, 1'b0, 2'd0, 8'sd0);
  endtask

  task automatic wr(input logic [1:0] addr, input logic signed [7:0] data);
    step(1'b0, 8'sd0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid_a"}, {63'd0, out_valid_a}, 64'd0);
    chk({tag, "_valid_b"}, {63'd0, out_valid_b}, 64'd0);
    chk({tag, "_terms_a"}, packed_a(), 64'd0);
    chk({tag, "_terms_b"}, packed_b(), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sym = '0; clear = 1'b0;
    wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Weights [1,2,3,4]; the 3-tap build ignores address 3.
    wr(2'd0, 8'sd1); wr(2'd1, 8'sd2); wr(2'd2, 8'sd3); wr(2'd3, 8'sd4);

    // Back-to-back fill then one more symbol.
    feed(8'sd10); feed(8'sd20); feed(8'sd30); feed(8'sd40); feed(8'sd50);
    idle(2);

    // Partial fill with a gap, then a single completing symbol.
    step(1'b0, 8'sd0, 1'b1, 1'b0, 2'd0, 8'sd0);
    feed(8'sd1); feed(8'sd2); idle(1); feed(8'sd3);
    idle(5);
    feed(8'sd4);
    idle(3);

    // Weight write on the same edge a symbol shifts in.
    step(1'b1, 8'sd2, 1'b0, 1'b1, 2'd0, 8'sd7);
    idle(2);
    wr(2'd3, -8'sd5);
    feed(8'sd6);
    idle(2);

    // Mid-stream clear with a simultaneous symbol and weight write.
    for (int i = 0; i < 6; i++) feed(8'($urandom_range(255)));
    step(1'b1, 8'sd99, 1'b1, 1'b1, 2'd1, 8'sd9);
    idle(1);
    for (int i = 0; i < 4; i++) feed(8'($urandom_range(255)));
    idle(2);

    // Saturation corners in the 10-bit build.
    wr(2'd0, -8'sd128); wr(2'd1, -8'sd128); wr(2'd2, 8'sd5);
    step(1'b0, 8'sd0, 1'b1, 1'b0, 2'd0, 8'sd0);
    feed(8'sd9); feed(8'sd3); feed(8'sd127); feed(-8'sd128);
    idle(2);

    // Random traffic with sparse weight writes.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(1)), 8'($urandom_range(255)), ($urandom_range(15) == 0),
           ($urandom_range(3) == 0), 2'($urandom_range(3)), 8'($urandom_range(255)));
    idle(2);

    // Async reset between edges while results are streaming.
    for (int i = 0; i < 5; i++) feed(8'($urandom_range(255)));
    @(negedge clk);
    check_outputs();
    in_valid = 1'b0; clear = 1'b0; wt_we = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) feed(8'($urandom_range(1, 127)));
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
